// File: rtl/axi4_lite_inv_slave.sv
// axi4_lite_inv_slave: AXI4-Lite register bank with three RW registers, a status register and an inverted REG0 output
module axi4_lite_inv_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_in,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   inv_out
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  logic          aw_held_q, aw_held_d;
  logic [2:0]    aw_idx_q, aw_idx_d;
  logic          w_held_q, w_held_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] reg_q [0:2];
  logic [DW-1:0] reg_d [0:2];
  logic [DW-1:0] inv_q, inv_d;
  logic          aw_hs, w_hs, ar_hs, commit;
  logic [2:0]    wr_idx, rd_idx;
  logic [DW-1:0] wr_data, rd_val;
  logic [SW-1:0] wr_strb;
  logic          unused_bits;
  assign unused_bits   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign inv_out       = inv_q;
  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
  assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[4:2];
  assign wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;
  assign rd_idx  = S_AXI_ARADDR[4:2];
  assign rd_val  = rd_idx == 3'd0 ? reg_q[0] :
                   rd_idx == 3'd1 ? reg_q[1] :
                   rd_idx == 3'd2 ? reg_q[2] :
                   rd_idx == 3'd3 ? status_in : '0;
  // write path: hold AW/W halves until both are present, then commit bytes and raise BVALID
  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q && !S_AXI_BREADY;
    bresp_d   = bresp_q;
    reg_d     = reg_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_idx >= 3'd3 ? 2'b10 : 2'b00;
      for (int r = 0; r < 3; r++)
        for (int b = 0; b < SW; b++)
          if (wr_idx == 3'(r) && wr_strb[b]) reg_d[r][8*b +: 8] = wr_data[8*b +: 8];
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = S_AXI_AWADDR[4:2];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = S_AXI_WDATA;
        w_strb_d = S_AXI_WSTRB;
      end
    end
  end
  // read path and inverted output: load response on AR handshake, hold until RREADY
  always_comb begin
    rvalid_d = ar_hs ? 1'b1 : rvalid_q && !S_AXI_RREADY;
    rdata_d  = ar_hs ? rd_val : rdata_q;
    rresp_d  = ar_hs ? {rd_idx[2], 1'b0} : rresp_q;
    inv_d    = ~reg_q[0];
  end
  // state registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      reg_q     <= '{default: '0};
      inv_q     <= '1;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      reg_q     <= reg_d;
      inv_q     <= inv_d;
    end
  end
endmodule

// File: doc/axi4_lite_inv_slave.md
Name: axi4_lite_inv_slave

Overview:
- AXI4-Lite responder (slave) with a small register bank.
- It is the target end of the transactions issued by the team's AXI4-Lite master BFM benches.
- Provides three read/write registers, one read-only status register, and a registered, bitwise-inverted copy of register 0 on a fabric output.
- Sits between the PS/interconnect master port and PL logic needing a software-controlled inverted signal.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; word index = addr[4:2], addr[1:0] ignored.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  / S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  / S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2  / S_AXI_BVALID  out  1  / S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  / S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32  / S_AXI_RRESP  out  2  / S_AXI_RVALID  out  1  / S_AXI_RREADY  in  1.
- status_in  in  32  value returned by register 3.
- inv_out  out  32  registered ~reg0.

Behaviour:
- Clocking and reset: one clock (ACLK); ARESET is synchronous, active-high.
- Register map (word index):
  - 0 = REG0 RW.
  - 1 = REG1 RW.
  - 2 = REG2 RW.
  - 3 = STATUS RO (reads status_in, sampled at AR handshake edge).
  - 4..7 unmapped.
- Reset values:
  - REG0/1/2 = 0; inv_out = 0xFFFFFFFF.
  - AWREADY = WREADY = ARREADY = 1.
  - BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0.
  - Write-address and write-data holding latches empty.
- Write channel:
  - AW and W are accepted independently, in any order, into one-deep holding latches.
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - Commit occurs on the edge where address and data are both available (held, or handshaking this cycle) and BVALID = 0.
  - At commit, target register bytes update per WSTRB (strobe 0 = byte unchanged). BVALID is set on the same edge and latches clear.
  - Minimum latency: AW+W handshake at edge N -> register updated and BVALID = 1 from cycle N+1.
  - BRESP = OKAY (00) for index 0..2.
  - BRESP = SLVERR (10) for index 3..7; no register changes.
  - BVALID holds, with BRESP stable, until BREADY sampled high. BVALID clears on that edge.
  - The next commit can occur no earlier than the edge after BVALID clears.
- Read channel:
  - ARREADY = !RVALID.
  - On AR handshake edge: RDATA is loaded, RVALID = 1.
  - RRESP = OKAY for index 0..3; RRESP = SLVERR with RDATA = 0 for index 4..7.
  - RVALID/RDATA/RRESP hold stable until RREADY high; RVALID clears on that edge.
  - Read-to-read throughput: 1 per 2 cycles.
- Simultaneous events:
  - Read and write are fully independent.
  - A read handshake on the same edge as a write commit to the same register returns the pre-write value.
  - WSTRB = 0 commits with OKAY and no change.
- inv_out = ~REG0, registered: reflects a REG0 write one cycle after the register update (two cycles after the write commit edge).
- ARESET asserted mid-transaction:
  - All outputs return to reset values on that edge.
  - Pending latches, BVALID and RVALID are dropped; no partial commit.
- AWADDR is captured when held; later changes on the bus while AWVALID is low do not affect a pending write.

Test Plan:
- Reset, then write 0x0101FFFF to 0x0 with AW and W in the same cycle -> BVALID at next cycle with BRESP = 00. Read 0x0 returns 0x0101FFFF with RRESP = 00. inv_out = 0xFEFE0000.
- W presented 3 cycles before AW (data 0xabcd0001, addr 0x4) -> WREADY drops after the W handshake, and no BVALID until AW arrives. Then BVALID = 1 the next cycle, and a read of 0x4 returns 0xabcd0001.
- Write 0xdead0011 to 0x8, then 0xFFFFFFFF with WSTRB = 0b0101 -> readback 0xdeFF00FF.
- Write to 0xC -> BRESP = 10, STATUS unchanged. Drive status_in = 0xbeef0011 and read 0xC -> RDATA = 0xbeef0011, RRESP = 00. Read 0x14 -> RDATA = 0, RRESP = 10.
- Hold BREADY and RREADY low for 5 cycles -> BVALID/RVALID, data and resp stay stable. AWREADY, WREADY and ARREADY stay 0 throughout; a new AW offered meanwhile is accepted only after BREADY.
- Assert ARESET while a write is half-captured (AW only) -> after release, REG0..2 = 0, inv_out = 0xFFFFFFFF, no BVALID. Subsequent W alone produces no commit.
